// File: rtl/csa_nibble_seq_if.sv
// Operand/result handshake bundle for csa_nibble_seq.
// slave = adder side, master = source/consumer side; ovf only with CSA_SEQ_OVF_EN.
interface csa_nibble_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef CSA_SEQ_OVF_EN
    logic             ovf;
`endif

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
`ifdef CSA_SEQ_OVF_EN
        , output ovf
`endif
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
`ifdef CSA_SEQ_OVF_EN
        , input ovf
`endif
    );
endinterface

// File: rtl/csa_nibble_seq.sv
// Nibble-serial WIDTH-bit adder reusing one 4-bit carry-select slice.
// Ports: clk, rst_n (async low), bus (slave). Macro CSA_SEQ_OVF_EN adds ovf.
module csa_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    csa_nibble_seq_if.slave   bus
);
    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] ra, rb;
    logic [IDX_W-1:0] idx;
    logic             c;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic [IDX_W+1:0] base;
    logic [3:0]       na, nb;
    logic [4:0]       s0, s1, sel;
    logic             accept;

    assign accept = (state == IDLE) && bus.in_valid;

    // Slice: both carry cases precomputed, registered carry picks one.
    assign base = {idx, 2'b00};
    assign na   = 4'(ra >> base);
    assign nb   = 4'(rb >> base);
    assign s0   = {1'b0, na} + {1'b0, nb};
    assign s1   = {1'b0, na} + {1'b0, nb} + 5'd1;
    assign sel  = c ? s1 : s0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (bus.in_valid) state_n = RUN;
            RUN:  if (idx == LAST)  state_n = DONE;
            DONE: if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra     <= '0;
            rb     <= '0;
            idx    <= '0;
            c      <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            ra  <= bus.a;
            rb  <= bus.b;
            c   <= bus.cin;
            idx <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < N; i++) begin
                if (idx == IDX_W'(i)) sum_q[4*i +: 4] <= sel[3:0];
            end
            c   <= sel[4];
            idx <= idx + IDX_W'(1);
            if (idx == LAST) cout_q <= sel[4];
        end
    end

`ifdef CSA_SEQ_OVF_EN
    logic ovf_q;

    // MSB of the sum is sel[3] on the last nibble step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state == RUN && idx == LAST) begin
            ovf_q <= (ra[WIDTH-1] == rb[WIDTH-1]) &&
                     (sel[3] != ra[WIDTH-1]);
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_csa_nibble_seq.sv
// Randomized and directed bench for csa_nibble_seq (WIDTH=16).
// Reference: {cout,sum} = a+b+cin, plus signed-overflow rule.
module tb_csa_nibble_seq;
    localparam int W = 16;
    localparam int N = W / 4;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    csa_nibble_seq_if #(.WIDTH(W)) bus ();

    csa_nibble_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge, idle.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic oc, input int hold);
        logic [W:0] r;
        logic       ov;
        int         cyc;
        r  = (W+1)'(oa) + (W+1)'(ob) + (W+1)'(oc);
        ov = (oa[W-1] == ob[W-1]) && (r[W-1] != oa[W-1]);
        chk("idle_ready", bus.in_ready, 1);
        bus.a         = oa;
        bus.b         = ob;
        bus.cin       = oc;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.cin      = 1'($urandom);
        for (cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) break;
            chk("run_busy", bus.busy, 1);
            chk("run_ready", bus.in_ready, 0);
            @(posedge clk);
        end
        chk("latency", cyc, N);
        if (cyc >= 20) return;
        chk("sum", bus.sum, r[W-1:0]);
        chk("cout", bus.cout, r[W]);
`ifdef CSA_SEQ_OVF_EN
        chk("ovf", bus.ovf, ov);
`endif
        chk("done_ready", bus.in_ready, 0);
        chk("done_busy", bus.busy, 1);
        if (hold > 0) begin
            bus.in_valid = 1'b1;
            repeat (hold) begin
                bus.a   = W'($urandom);
                bus.b   = W'($urandom);
                bus.cin = 1'($urandom);
                @(posedge clk);
                @(negedge clk);
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_sum", bus.sum, r[W-1:0]);
                chk("hold_cout", bus.cout, r[W]);
                chk("hold_ready", bus.in_ready, 0);
            end
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("ret_valid", bus.out_valid, 0);
        chk("ret_ready", bus.in_ready, 1);
        chk("ret_busy", bus.busy, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        #12;
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h1234, 16'h4321, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 0);
        run_op(16'h0000, 16'h0000, 1'b0, 0);
        run_op(16'hABCD, 16'h1357, 1'b1, 6);

        // Reset in the middle of a run.
        bus.a        = 16'h00FF;
        bus.b        = 16'h0001;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", bus.in_ready, 1);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_sum", bus.sum, 0);
        chk("mid_rst_cout", bus.cout, 0);
`ifdef CSA_SEQ_OVF_EN
        chk("mid_rst_ovf", bus.ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_valid", bus.out_valid, 0);
        end
        run_op(16'h0010, 16'h0020, 1'b0, 0);

`ifdef CSA_SEQ_OVF_EN
        run_op(16'h7FFF, 16'h0001, 1'b0, 0);
        run_op(16'h8000, 16'h8000, 1'b0, 0);
        run_op(16'h1000, 16'h2000, 1'b0, 0);
`endif

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/csa_nibble_seq.md
# csa_nibble_seq

Multi-cycle sequencer that performs a WIDTH-bit addition by reusing one 4-bit carry-select adder slice, processing one nibble per clock from LSB to MSB. A registered carry links successive nibbles. Operands arrive through a valid/ready input handshake and results leave through a valid/ready output handshake. The block sits between an operand source and a result consumer wherever a full-width parallel adder is too costly.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (N = WIDTH/4 nibbles).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  addend.
- b  input  WIDTH  addend.
- cin  input  1  carry-in to nibble 0.
- out_valid  output  1  sum/cout are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered result.
- cout  output  1  carry-out of the MSB nibble.
- busy  output  1  high in RUN or DONE.
- ovf  output  1  signed overflow; present only with CSA_SEQ_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture a, b, cin into internal registers; nibble index idx=0; carry register c=cin; go to RUN.
- RUN: each cycle, for nibble idx compute s0=A[idx]+B[idx]+0 and s1=A[idx]+B[idx]+1 (5-bit each), then select s1 when c=1, else s0. Write the low 4 bits to sum[4*idx+3:4*idx]; load bit 4 into c; increment idx. After processing idx=N-1, load cout from the selected bit 4 and go to DONE.
- DONE: out_valid=1. sum, cout and ovf are held stable. in_valid is ignored. On out_ready, go to IDLE.
- sum bits are updated nibble-by-nibble during RUN. Consumers sample them only while out_valid=1.
- Arithmetic is unsigned modulo 2^WIDTH. {cout,sum} = a+b+cin exactly.
- Reset (rst_n=0, at any time including mid-RUN or DONE): state=IDLE, idx=0, c=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1. Any in-flight operation is discarded and produces no result.
- Operand inputs are sampled only at the accept edge. Later changes on a, b or cin do not affect the operation in progress.

## Timing
- Accept at edge E0. Nibbles 0..N-1 are processed at edges E1..EN. out_valid rises after EN, which is N cycles after accept (4 cycles for WIDTH=16).
- If out_ready is high when out_valid rises, the output handshake completes at EN+1. in_ready is high after EN+1, and the next accept can occur at EN+2. Minimum initiation interval is N+2 cycles.
- in_ready and out_valid are decoded directly from the state register with no combinational path from inputs. They are never high in the same cycle.
- out_ready asserted outside DONE has no effect.

## Configuration
- CSA_SEQ_OVF_EN defined: port ovf exists. ovf is registered at the MSB nibble step and equals (a[WIDTH-1]==b[WIDTH-1]) && (sum[WIDTH-1]!=a[WIDTH-1]), using the captured operands. It is valid with out_valid and is 0 after reset.
- CSA_SEQ_OVF_EN undefined: port ovf and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0 -> out_valid high exactly 4 cycles after accept, sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. The carry propagates through all four nibble steps.
- a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1. Then a=0x0000, b=0x0000, cin=0 back-to-back with out_ready=1 -> accepted at EN+2, sum=0x0000, cout=0.
- Hold out_ready=0 for 6 cycles in DONE while driving in_valid=1 with new operands -> sum/cout stable, in_ready=0, new operands not captured. Then out_ready=1 -> IDLE next cycle.
- Assert rst_n=0 after 2 nibble steps of 0x00FF+0x0001 -> all outputs immediately at reset values, no out_valid. After release, 0x0010+0x0020 -> sum=0x0030.
- With CSA_SEQ_OVF_EN: 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1. 0x8000+0x8000 -> sum=0x0000, cout=1, ovf=1. 0x1000+0x2000 -> ovf=0.
